multicore_bus_arbiter: RTL and testbench
========================================

Name: multicore_bus_arbiter

Overview:
Parametrised successor to the two-core system bus. Arbitrates NUM_CORES cores onto one shared memory port. Decodes each granted access to RAM or GPIO using the address MSB. Adds round-robin or fixed-priority arbitration, a bounded ownership window with forced release, and a registered read-data return path with a valid strobe.

Parameters:
NUM_CORES, 2, number of requesting cores (2..8)
DATA_W, 8, data width
ADDR_W, 10, core address width; bit ADDR_W-1 = GPIO select, lower ADDR_W-1 bits = target offset
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round robin
MAX_HOLD, 16, max consecutive owned cycles before forced release (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
core_request  in  NUM_CORES  per-core bus request
core_grant  out  NUM_CORES  per-core grant, one-hot or zero
core_rw  in  NUM_CORES  per-core access type, 1 = write, 0 = read
core_address  in  NUM_CORES*ADDR_W  packed core addresses, core i at [i*ADDR_W +: ADDR_W]
core_wdata  in  NUM_CORES*DATA_W  packed core write data
core_rdata  out  DATA_W  read data, broadcast to all cores
core_rvalid  out  NUM_CORES  one-cycle read-data-valid strobe for the core that issued the read
ram_en  out  1  RAM access strobe
ram_rw  out  1  RAM write enable
ram_address  out  ADDR_W-1  RAM offset
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en
gpio_en  out  1  GPIO access strobe
gpio_rw  out  1  GPIO write enable
gpio_address  out  ADDR_W-1  GPIO offset
gpio_wdata  out  DATA_W  GPIO write data
gpio_rdata  in  DATA_W  GPIO read data, valid one cycle after gpio_en

Behaviour:
- Reset (reset=0, async): state IDLE, core_grant=0, core_rvalid=0, core_rdata=0, hold counter=0, RR pointer=NUM_CORES-1 (core0 searched first). All en/rw outputs are 0. Address and wdata outputs are 0 when en=0.
- FSM IDLE:
  - If any core_request is set, pick a winner and enter OWNED next edge. core_grant[winner] is registered, so it rises one cycle after the request is sampled.
  - ARB_MODE=0: lowest asserted index wins.
  - ARB_MODE=1: search starts at pointer+1 and wraps modulo NUM_CORES. Pointer is updated to the winner on grant.
- FSM OWNED:
  - Each cycle with core_request[owner]=1 is one access. Forward owner rw/address/wdata combinationally.
  - address MSB=0 drives ram_en=1. address MSB=1 drives gpio_en=1. Never both.
  - Hold counter increments per owned cycle.
- Release:
  - Owner drops its request: grant clears next edge, no access that cycle, return to IDLE.
  - Hold counter reaches MAX_HOLD: forced release. Grant clears next edge after the MAX_HOLD-th access, return to IDLE.
- IDLE always lasts at least one cycle between owners (turnaround). No back-to-back grants to different cores.
- Read return: a read issued at cycle t registers the source (RAM/GPIO) and the owner index. At t+1, core_rdata = selected rdata and core_rvalid[owner]=1 for exactly one cycle. This holds even if the grant was released at t+1.
- Writes produce no rvalid.
- Requests from non-owners are ignored while OWNED. They stay pending, with no loss and no queueing beyond the level request.
- Reset mid-access: the pending rvalid is dropped and the grant clears immediately.
- Counter width: clog2(MAX_HOLD+1); no wrap occurs because release fires at MAX_HOLD.

Test Plan:
- Reset, single requester: core1 requests reads at address 0x005 (RAM) -> grant[1] rises one cycle later; ram_en=1, ram_address=0x005; core_rvalid[1] one cycle after with core_rdata = RAM value.
- GPIO decode: core0 writes 0xA5 to address 0x203 -> gpio_en=1, gpio_rw=1, gpio_address=0x003, gpio_wdata=0xA5; ram_en stays 0; no rvalid.
- Round robin, ARB_MODE=1, NUM_CORES=4, all request continuously -> grant order 0,1,2,3,0, each owner separated by one IDLE cycle.
- Fixed priority, ARB_MODE=0, cores 1 and 2 request -> core1 always wins; core2 is granted only after core1 drops its request.
- Forced release, MAX_HOLD=4, core0 holds its request indefinitely with core1 also requesting -> exactly 4 accesses by core0, grant drops, one IDLE cycle, then grant[1] (RR).
- Async reset asserted mid-read -> core_grant, en and rvalid outputs go to 0 immediately without a clock edge; after release, core0 has first priority.

Source files
------------

// File: rtl/multicore_bus_arbiter.sv
// NUM_CORES-way arbiter onto one RAM/GPIO port, address MSB selects GPIO; grant is registered (1 cycle after request).
// Read data returns 1 cycle after the access with a per-core valid; non-owners simply hold their level request.
module multicore_bus_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter int ARB_MODE  = 1,
    parameter int MAX_HOLD  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          core_request,
    output logic [NUM_CORES-1:0]          core_grant,
    input  logic [NUM_CORES-1:0]          core_rw,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_address,
    input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
    output logic [DATA_W-1:0]             core_rdata,
    output logic [NUM_CORES-1:0]          core_rvalid,
    output logic                          ram_en,
    output logic                          ram_rw,
    output logic [ADDR_W-2:0]             ram_address,
    output logic [DATA_W-1:0]             ram_wdata,
    input  logic [DATA_W-1:0]             ram_rdata,
    output logic                          gpio_en,
    output logic                          gpio_rw,
    output logic [ADDR_W-2:0]             gpio_address,
    output logic [DATA_W-1:0]             gpio_wdata,
    input  logic [DATA_W-1:0]             gpio_rdata
);
    localparam int IDX_W = $clog2(NUM_CORES);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {S_IDLE, S_OWNED} state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_owner;
    logic [IDX_W-1:0]       r_ptr;
    logic [CNT_W-1:0]       r_hold;
    logic [NUM_CORES-1:0]   r_grant;
    logic                   r_rd_vld;
    logic                   r_rd_gpio;
    logic [IDX_W-1:0]       r_rd_owner;

    logic [IDX_W-1:0]       w_win;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_found;
    logic                   w_acc;
    logic                   w_rw;
    logic                   w_gpio;
    logic [ADDR_W-1:0]      w_addr;
    logic [DATA_W-1:0]      w_wdata;

    // Round robin starts the search just after the previous winner; fixed priority always from core 0.
    always_comb begin
        w_win   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (ARB_MODE == 0) begin
                w_idx = IDX_W'(k);
            end else begin
                w_idx = IDX_W'((int'(r_ptr) + 1 + k) % NUM_CORES);
            end
            if (!w_found && core_request[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_addr  = core_address[r_owner*ADDR_W +: ADDR_W];
    assign w_wdata = core_wdata[r_owner*DATA_W +: DATA_W];
    assign w_rw    = core_rw[r_owner];
    assign w_gpio  = w_addr[ADDR_W-1];
    assign w_acc   = (r_state == S_OWNED) && core_request[r_owner];

    assign ram_en       = w_acc && !w_gpio;
    assign ram_rw       = ram_en && w_rw;
    assign ram_address  = ram_en ? w_addr[ADDR_W-2:0] : '0;
    assign ram_wdata    = ram_en ? w_wdata : '0;
    assign gpio_en      = w_acc && w_gpio;
    assign gpio_rw      = gpio_en && w_rw;
    assign gpio_address = gpio_en ? w_addr[ADDR_W-2:0] : '0;
    assign gpio_wdata   = gpio_en ? w_wdata : '0;

    assign core_grant  = r_grant;
    assign core_rvalid = r_rd_vld ? (NUM_CORES'(1) << r_rd_owner) : '0;
    assign core_rdata  = !r_rd_vld ? '0 : (r_rd_gpio ? gpio_rdata : ram_rdata);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_ptr      <= IDX_W'(NUM_CORES - 1);
            r_hold     <= '0;
            r_grant    <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_gpio  <= 1'b0;
            r_rd_owner <= '0;
        end else begin
            r_rd_vld   <= w_acc && !w_rw;
            r_rd_gpio  <= w_gpio;
            r_rd_owner <= r_owner;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_OWNED;
                        r_owner <= w_win;
                        r_grant <= NUM_CORES'(1) << w_win;
                        r_hold  <= '0;
                        if (ARB_MODE != 0) begin
                            r_ptr <= w_win;
                        end
                    end
                end
                S_OWNED: begin
                    if (w_acc) begin
                        r_hold <= r_hold + 1'b1;
                    end
                    // Release on request drop, or right after the MAX_HOLD-th access.
                    if (!w_acc || r_hold == CNT_W'(MAX_HOLD - 1)) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicore_bus_arbiter.sv
// Two arbiters (fixed priority and round robin) share one random stimulus stream and are
// compared every cycle against an ownership/read-return reference model.
module tb_multicore_bus_arbiter;
    localparam int NC = 4;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int MH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     req;
    logic [NC-1:0]     rw;
    logic [NC*AW-1:0]  addr;
    logic [NC*DW-1:0]  wdata;

    logic [NC-1:0]     grant    [2];
    logic [NC-1:0]     rvalid   [2];
    logic [DW-1:0]     rdata    [2];
    logic [1:0]        ram_en;
    logic [1:0]        ram_rw;
    logic [AW-2:0]     ram_addr [2];
    logic [DW-1:0]     ram_wd   [2];
    logic [DW-1:0]     ram_rd   [2];
    logic [1:0]        gpio_en;
    logic [1:0]        gpio_rw;
    logic [AW-2:0]     gpio_addr[2];
    logic [DW-1:0]     gpio_wd  [2];
    logic [DW-1:0]     gpio_rd  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        multicore_bus_arbiter #(
            .NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW), .ARB_MODE(g), .MAX_HOLD(MH)
        ) u_dut (
            .clk(clk), .reset(rst_n),
            .core_request(req), .core_grant(grant[g]), .core_rw(rw),
            .core_address(addr), .core_wdata(wdata),
            .core_rdata(rdata[g]), .core_rvalid(rvalid[g]),
            .ram_en(ram_en[g]), .ram_rw(ram_rw[g]), .ram_address(ram_addr[g]),
            .ram_wdata(ram_wd[g]), .ram_rdata(ram_rd[g]),
            .gpio_en(gpio_en[g]), .gpio_rw(gpio_rw[g]), .gpio_address(gpio_addr[g]),
            .gpio_wdata(gpio_wd[g]), .gpio_rdata(gpio_rd[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state per DUT (index 0 = fixed priority, 1 = round robin).
    int          m_owner  [2];
    int          m_hold   [2];
    int          m_last   [2];
    bit          m_rd_pend[2];
    int          m_rd_core[2];
    logic [7:0]  m_rd_data[2];
    logic [7:0]  nx_ram   [2];
    logic [7:0]  nx_gpio  [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d]   = -1;
            m_hold[d]    = 0;
            m_last[d]    = NC - 1;
            m_rd_pend[d] = 1'b0;
            m_rd_core[d] = 0;
            m_rd_data[d] = 8'h00;
        end
    endtask

    function automatic logic [7:0] ram_val(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    function automatic logic [7:0] gpio_val(input logic [7:0] a);
        return a ^ 8'hC3;
    endfunction

    task automatic check_and_step();
        for (int d = 0; d < 2; d++) begin
            int          o;
            bit          acc;
            logic [9:0]  a;
            logic [7:0]  wd;
            bit          g;
            bit          w;
            logic [31:0] rnd;
            o   = m_owner[d];
            acc = (o >= 0) && req[o];
            a   = (o >= 0) ? addr[o*AW +: AW] : 10'h0;
            wd  = (o >= 0) ? wdata[o*DW +: DW] : 8'h0;
            g   = a[9];
            w   = (o >= 0) ? rw[o] : 1'b0;

            check_eq($sformatf("d%0d grant", d), 32'(grant[d]), (o >= 0) ? 32'(1) << o : 32'(0));
            check_eq($sformatf("d%0d ram_en", d), 32'(ram_en[d]), 32'(acc && !g));
            check_eq($sformatf("d%0d gpio_en", d), 32'(gpio_en[d]), 32'(acc && g));
            check_eq($sformatf("d%0d ram_rw", d), 32'(ram_rw[d]), 32'(acc && !g && w));
            check_eq($sformatf("d%0d gpio_rw", d), 32'(gpio_rw[d]), 32'(acc && g && w));
            check_eq($sformatf("d%0d ram_addr", d), 32'(ram_addr[d]), (acc && !g) ? 32'(a[8:0]) : 32'(0));
            check_eq($sformatf("d%0d gpio_addr", d), 32'(gpio_addr[d]), (acc && g) ? 32'(a[8:0]) : 32'(0));
            check_eq($sformatf("d%0d ram_wdata", d), 32'(ram_wd[d]), (acc && !g) ? 32'(wd) : 32'(0));
            check_eq($sformatf("d%0d gpio_wdata", d), 32'(gpio_wd[d]), (acc && g) ? 32'(wd) : 32'(0));
            check_eq($sformatf("d%0d rvalid", d), 32'(rvalid[d]),
                     m_rd_pend[d] ? 32'(1) << m_rd_core[d] : 32'(0));
            if (m_rd_pend[d]) begin
                check_eq($sformatf("d%0d rdata", d), 32'(rdata[d]), 32'(m_rd_data[d]));
            end

            // Memory responders answer whatever the DUT actually drove, one cycle later.
            rnd = $urandom;
            nx_ram[d]  = (ram_en[d] && !ram_rw[d]) ? ram_val(ram_addr[d][7:0]) : rnd[7:0];
            nx_gpio[d] = (gpio_en[d] && !gpio_rw[d]) ? gpio_val(gpio_addr[d][7:0]) : rnd[15:8];

            m_rd_pend[d] = acc && !w;
            m_rd_core[d] = o;
            m_rd_data[d] = g ? gpio_val(a[7:0]) : ram_val(a[7:0]);

            if (o < 0) begin
                if (req != '0) begin
                    int win;
                    win = -1;
                    for (int k = 1; k <= NC; k++) begin
                        int c;
                        c = (d == 0) ? (k - 1) : ((m_last[d] + k) % NC);
                        if (win < 0 && req[c]) win = c;
                    end
                    m_owner[d] = win;
                    m_hold[d]  = 0;
                    m_last[d]  = win;
                end
            end else if (!acc) begin
                m_owner[d] = -1;
            end else begin
                m_hold[d]++;
                if (m_hold[d] == MH) m_owner[d] = -1;
            end
        end
    endtask

    task automatic cycle();
        #1;
        check_and_step();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            ram_rd[d]  = nx_ram[d];
            gpio_rd[d] = nx_gpio[d];
        end
        @(negedge clk);
    endtask

    task automatic randomize_access();
        for (int i = 0; i < NC; i++) begin
            rw[i]             = 1'($urandom_range(1));
            addr[i*AW +: AW]  = 10'($urandom_range(1023));
            wdata[i*DW +: DW] = 8'($urandom_range(255));
        end
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        req   = '0;
        rw    = '0;
        addr  = '0;
        wdata = '0;
        for (int d = 0; d < 2; d++) begin
            ram_rd[d]  = 8'h00;
            gpio_rd[d] = 8'h00;
        end
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rst d%0d grant", d), 32'(grant[d]), 32'(0));
            check_eq($sformatf("rst d%0d rvalid", d), 32'(rvalid[d]), 32'(0));
            check_eq($sformatf("rst d%0d rdata", d), 32'(rdata[d]), 32'(0));
            check_eq($sformatf("rst d%0d en", d), 32'({ram_en[d], gpio_en[d], ram_rw[d], gpio_rw[d]}), 32'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Single RAM reader, then a GPIO writer.
        req = 4'b0010; rw = '0; addr[1*AW +: AW] = 10'h005;
        repeat (4) cycle();
        req = 4'b0000;
        repeat (2) cycle();
        req = 4'b0001; rw = 4'b0001; addr[0 +: AW] = 10'h203; wdata[0 +: DW] = 8'hA5;
        repeat (3) cycle();
        req = 4'b0000;
        repeat (2) cycle();

        // Everyone requesting: exercises rotation, turnaround and forced release.
        req = 4'b1111;
        repeat (40) begin randomize_access(); cycle(); end
        // Cores 1 and 2 competing; core 1 then drops.
        req = 4'b0110;
        repeat (16) begin randomize_access(); cycle(); end
        req = 4'b0100;
        repeat (6) begin randomize_access(); cycle(); end

        // Long random run with slowly toggling level requests.
        repeat (3000) begin
            for (int i = 0; i < NC; i++) begin
                if ($urandom_range(7) == 0) req[i] = ~req[i];
            end
            randomize_access();
            cycle();
        end

        // Async reset while a read return is outstanding.
        req = '0;
        repeat (3) cycle();
        req = 4'b0001; rw = '0; addr[0 +: AW] = 10'h010;
        guard = 0;
        while (!(m_rd_pend[0] && m_rd_pend[1]) && guard < 20) begin
            cycle();
            guard++;
        end
        check_eq("midread setup reached", 32'(guard < 20), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("arst d%0d grant", d), 32'(grant[d]), 32'(0));
            check_eq($sformatf("arst d%0d rvalid", d), 32'(rvalid[d]), 32'(0));
            check_eq($sformatf("arst d%0d en", d), 32'({ram_en[d], gpio_en[d]}), 32'(0));
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1111;
        repeat (20) begin randomize_access(); cycle(); end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
